// File: rtl/anubis_key_sched_if.sv
// Handshake/bus bundle between the Anubis key-schedule sequencer and its
// surroundings (start/key load, external evolution datapath, round-key sink).
//   start, key_in       : schedule launch and cipher key K^0
//   evo_state/evo_result: current key state out, evolved state back (comb.)
//   rk_*                : valid/ready stream of evolved key states
//   busy, done          : status; done pulses once per finished schedule
// The master modport is the sequencer side, slave is the environment side.
interface anubis_key_sched_if;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] evo_state;
  logic [127:0] evo_result;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_index;
  logic         rk_last;
  logic         busy;
  logic         done;

  modport master (
    input  start, key_in, evo_result, rk_ready,
    output evo_state, rk_valid, rk_data, rk_index, rk_last, busy, done
  );

  modport slave (
    output start, key_in, evo_result, rk_ready,
    input  evo_state, rk_valid, rk_data, rk_index, rk_last, busy, done
  );
endinterface

// File: rtl/anubis_key_sched_ctrl.sv
// Anubis 128-bit key evolution sequencer (N=4). Holds the single key-state
// register, drives it to an external gamma/pi/theta datapath, folds in the
// round constant and streams K^0..K^ROUNDS out over valid/ready.
// Ports:
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : anubis_key_sched_if.master (see interface file)
// ROUNDS must lie in 1..15; the round constant index is only 4 bits wide.
//
// state  | meaning
// IDLE   | waiting for start; busy low
// EMIT   | KS/idx presented on rk_data/rk_index with rk_valid high
// EVOLVE | KS <= evo_result ^ c^(idx+1), idx advances

// Round constants c^r for the 4-row key: row 0 holds S-box entries
// S[4(r-1)..4(r-1)+3], every other byte is zero. Round 0 has no constant.
module Round_Constants (
  input  logic [3:0]   round_counter,
  output logic [127:0] rc
);
  logic [31:0] row0;

  always_comb begin
    row0 = 32'h0;
    case (round_counter)
      4'd1:  row0 = 32'ha7d3e671;
      4'd2:  row0 = 32'hd0ac4d79;
      4'd3:  row0 = 32'h3ac991fc;
      4'd4:  row0 = 32'h1e4754bd;
      4'd5:  row0 = 32'h8ca57afb;
      4'd6:  row0 = 32'h63b8ddd4;
      4'd7:  row0 = 32'he5b3c5be;
      4'd8:  row0 = 32'ha9880ca2;
      4'd9:  row0 = 32'h39df29da;
      4'd10: row0 = 32'h2ba8cb4c;
      4'd11: row0 = 32'h4b22aa24;
      4'd12: row0 = 32'h4170a6f9;
      4'd13: row0 = 32'h5ae2b036;
      4'd14: row0 = 32'h7de433ff;
      4'd15: row0 = 32'h6020088b;
      default: row0 = 32'h0;
    endcase
  end

  assign rc = {row0, 96'h0};
endmodule

module anubis_key_sched_ctrl #(
  parameter int ROUNDS = 12
) (
  input  logic clk,
  input  logic rst,
  anubis_key_sched_if.master bus
);
  localparam logic [3:0] LAST_IDX = 4'(ROUNDS);

  typedef enum logic [1:0] {IDLE, EMIT, EVOLVE} state_t;

  state_t       state_q, state_d;
  logic [127:0] ks_q, ks_d;
  logic [3:0]   idx_q, idx_d;
  logic         done_q, done_d;
  logic [3:0]   rc_round;
  logic [127:0] rc;
  logic         valid;
  logic         last;

  // Constant for the round being produced; wraps naturally in 4 bits.
  assign rc_round = idx_q + 4'd1;

  Round_Constants u_round_constants (
    .round_counter(rc_round),
    .rc           (rc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ks_q    <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ks_q    <= ks_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ks_d    = ks_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    valid   = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          ks_d    = bus.key_in;
          idx_d   = 4'd0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        valid = 1'b1;
        last  = (idx_q == LAST_IDX);
        if (bus.rk_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = EVOLVE;
          end
        end
      end
      EVOLVE: begin
        ks_d    = bus.evo_result ^ rc;
        idx_d   = idx_q + 4'd1;
        state_d = EMIT;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.evo_state = ks_q;
  assign bus.rk_data   = ks_q;
  assign bus.rk_index  = idx_q;
  assign bus.rk_valid  = valid;
  assign bus.rk_last   = last;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
endmodule

// File: tb/tb_anubis_key_sched_ctrl.sv
// Self-checking bench for anubis_key_sched_ctrl. A reference model builds
// the expected key sequence from the Anubis S-box, a gamma/pi/theta key
// evolution and the round-constant rule, and the DUT stream is compared
// against it under stalls, ignored restarts, reset and back-to-back starts.
module tb_anubis_key_sched_ctrl;
  localparam int R = 12;

  localparam logic [7:0] SBOX [0:255] = '{
    8'ha7,8'hd3,8'he6,8'h71,8'hd0,8'hac,8'h4d,8'h79,8'h3a,8'hc9,8'h91,8'hfc,8'h1e,8'h47,8'h54,8'hbd,
    8'h8c,8'ha5,8'h7a,8'hfb,8'h63,8'hb8,8'hdd,8'hd4,8'he5,8'hb3,8'hc5,8'hbe,8'ha9,8'h88,8'h0c,8'ha2,
    8'h39,8'hdf,8'h29,8'hda,8'h2b,8'ha8,8'hcb,8'h4c,8'h4b,8'h22,8'haa,8'h24,8'h41,8'h70,8'ha6,8'hf9,
    8'h5a,8'he2,8'hb0,8'h36,8'h7d,8'he4,8'h33,8'hff,8'h60,8'h20,8'h08,8'h8b,8'h5e,8'hab,8'h7f,8'h78,
    8'h7c,8'h2c,8'h57,8'hd2,8'hdc,8'h6d,8'h7e,8'h0d,8'h53,8'h94,8'hc3,8'h28,8'h27,8'h06,8'h5f,8'had,
    8'h67,8'h5c,8'h55,8'h48,8'h0e,8'h52,8'hea,8'h42,8'h5b,8'h5d,8'h30,8'h58,8'h51,8'h59,8'h3c,8'h4e,
    8'h38,8'h8a,8'h72,8'h14,8'he7,8'hc6,8'hde,8'h50,8'h8e,8'h92,8'hd1,8'h77,8'h93,8'h45,8'h9a,8'hce,
    8'h2d,8'h03,8'h62,8'hb6,8'hb9,8'hbf,8'h96,8'h6b,8'h3f,8'h07,8'h12,8'hae,8'h40,8'h34,8'h46,8'h3e,
    8'hdb,8'hcf,8'hec,8'hcc,8'hc1,8'ha1,8'hc0,8'hd6,8'h1d,8'hf4,8'h61,8'h3b,8'h10,8'hd8,8'h68,8'ha0,
    8'hb1,8'h0a,8'h69,8'h6c,8'h49,8'hfa,8'h76,8'hc4,8'h9e,8'h9b,8'h6e,8'h99,8'hc2,8'hb7,8'h98,8'hbc,
    8'h8f,8'h85,8'h1f,8'hb4,8'hf8,8'h11,8'h2e,8'h00,8'h25,8'h1c,8'h2a,8'h3d,8'h05,8'h4f,8'h7b,8'hb2,
    8'h32,8'h90,8'haf,8'h19,8'ha3,8'hf7,8'h73,8'h9d,8'h15,8'h74,8'hee,8'hca,8'h9f,8'h0f,8'h1b,8'h75,
    8'h86,8'h84,8'h9c,8'h4a,8'h97,8'h1a,8'h65,8'hf6,8'hed,8'h09,8'hbb,8'h26,8'h83,8'heb,8'h6f,8'h81,
    8'h04,8'h6a,8'h43,8'h01,8'h17,8'he1,8'h87,8'hf5,8'h8d,8'he3,8'h23,8'h80,8'h44,8'h16,8'h66,8'h21,
    8'hfe,8'hd5,8'h31,8'hd9,8'h35,8'h18,8'h02,8'h64,8'hf2,8'hf1,8'h56,8'hcd,8'h82,8'hc8,8'hba,8'hf0,
    8'hef,8'he9,8'he8,8'hfd,8'h89,8'hd7,8'hc7,8'hb5,8'ha4,8'h2f,8'h95,8'h13,8'h0b,8'hf3,8'he0,8'h37
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  anubis_key_sched_if bus_if ();

  anubis_key_sched_ctrl #(.ROUNDS(R)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int errors = 0;
  int checks = 0;
  bit golden = 1'b0;
  logic [127:0] exp_keys [0:15];
  logic [127:0] seen [0:15];
  int hs_cnt;
  int last_cnt;
  int done_cyc;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) r ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1d : 8'h00);
      y = y >> 1;
    end
    return r;
  endfunction

  // Key evolution without constant: S-box per byte, column j rotated down
  // by j rows, then each row multiplied by had(01,02,04,06) over GF(2^8).
  function automatic logic [127:0] evo_fn(input logic [127:0] s);
    logic [7:0] g [4][4];
    logic [7:0] p [4][4];
    logic [7:0] h [4];
    logic [7:0] t;
    logic [127:0] o = '0;
    h = '{8'h01, 8'h02, 8'h04, 8'h06};
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        g[i][j] = SBOX[s[127-8*(4*i+j) -: 8]];
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        p[i][j] = g[(i - j + 4) % 4][j];
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        t = 8'h00;
        for (int k = 0; k < 4; k++) t ^= gmul(p[i][k], h[k ^ j]);
        o[127-8*(4*i+j) -: 8] = t;
      end
    return o;
  endfunction

  function automatic logic [127:0] rc_of(input int r);
    logic [127:0] v = '0;
    for (int j = 0; j < 4; j++) v[127-8*j -: 8] = SBOX[4*(r-1)+j];
    return v;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always_comb bus_if.evo_result = golden ? evo_fn(bus_if.evo_state) : bus_if.evo_state;

  task automatic build_expected(input logic [127:0] key);
    exp_keys[0] = key;
    for (int r = 1; r <= R; r++)
      exp_keys[r] = (golden ? evo_fn(exp_keys[r-1]) : exp_keys[r-1]) ^ rc_of(r);
  endtask

  // Runs one schedule starting from IDLE. stall_at: index held off for 5
  // cycles; restart_at: index at which a foreign start is pulsed; rst_at:
  // index at which reset is applied (task returns after reset checks);
  // hold_start: keep start high throughout, returning in the done cycle.
  task automatic run_sched(input logic [127:0] key, input int stall_at, input int restart_at,
                           input int rst_at, input bit hold_start);
    int idx_e = 0;
    int stall = 0;
    int last_hs = 0;
    int cyc = 0;
    bit first = 1'b1;
    bit prev_stall = 1'b0;
    bit got_done = 1'b0;
    build_expected(key);
    hs_cnt = 0;
    last_cnt = 0;
    done_cyc = -1;
    for (int i = 0; i < 16; i++) seen[i] = '0;
    bus_if.start = 1'b1;
    bus_if.key_in = key;
    bus_if.rk_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.key_in = ~key;
    while (cyc < 200) begin
      bus_if.start = hold_start;
      if (bus_if.done) begin
        got_done = 1'b1;
        done_cyc = cyc;
        break;
      end
      if (prev_stall) chk("valid_held", 128'(bus_if.rk_valid), 128'(1));
      chk("busy_active", 128'(bus_if.busy), 128'(1));
      if (bus_if.rk_valid) begin
        if (first) begin
          if (idx_e > 0) chk("key_gap", 128'(cyc - last_hs), 128'(2));
          first = 1'b0;
          if (idx_e == restart_at) bus_if.start = 1'b1;
          if (idx_e == rst_at) begin
            rst = 1'b1;
            @(posedge clk); #1;
            chk("rst_valid", 128'(bus_if.rk_valid), 128'(0));
            chk("rst_busy", 128'(bus_if.busy), 128'(0));
            chk("rst_index", 128'(bus_if.rk_index), 128'(0));
            chk("rst_done", 128'(bus_if.done), 128'(0));
            chk("rst_data", bus_if.rk_data, 128'(0));
            rst = 1'b0;
            @(posedge clk); #1;
            return;
          end
        end
        chk("rk_index", 128'(bus_if.rk_index), 128'(idx_e));
        chk("rk_data", bus_if.rk_data, exp_keys[idx_e]);
        chk("rk_last", 128'(bus_if.rk_last), 128'(idx_e == R));
        seen[idx_e] = bus_if.rk_data;
        if (idx_e == stall_at && stall < 5) begin
          bus_if.rk_ready = 1'b0;
          stall++;
        end else begin
          bus_if.rk_ready = 1'b1;
        end
        prev_stall = !bus_if.rk_ready;
        if (bus_if.rk_ready) begin
          hs_cnt++;
          if (bus_if.rk_last) last_cnt++;
          last_hs = cyc;
          idx_e++;
          first = 1'b1;
        end
      end else begin
        bus_if.rk_ready = 1'($urandom_range(0, 1));
        prev_stall = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_seen", 128'(got_done), 128'(1));
    chk("handshakes", 128'(hs_cnt), 128'(R + 1));
    chk("last_count", 128'(last_cnt), 128'(1));
    chk("done_cycle", 128'(done_cyc), 128'(2 * R + 1 + stall));
    chk("done_busy", 128'(bus_if.busy), 128'(0));
    chk("done_valid", 128'(bus_if.rk_valid), 128'(0));
    if (!hold_start) begin
      bus_if.start = 1'b0;
      @(posedge clk); #1;
      chk("done_pulse", 128'(bus_if.done), 128'(0));
      chk("idle_busy", 128'(bus_if.busy), 128'(0));
    end
  endtask

  initial begin
    logic [127:0] k1;
    logic [127:0] k2;
    bus_if.start = 1'b0;
    bus_if.key_in = '0;
    bus_if.rk_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 128'(bus_if.rk_valid), 128'(0));
    chk("reset_last", 128'(bus_if.rk_last), 128'(0));
    chk("reset_busy", 128'(bus_if.busy), 128'(0));
    chk("reset_done", 128'(bus_if.done), 128'(0));
    chk("reset_data", bus_if.rk_data, 128'(0));
    chk("reset_index", 128'(bus_if.rk_index), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_hold", 128'(bus_if.busy), 128'(0));

    // Identity evolution, zero key: bare round constants accumulate.
    golden = 1'b0;
    run_sched('0, -1, -1, -1, 1'b0);
    chk("id_k0", seen[0], 128'(0));
    chk("id_k1", seen[1], {32'ha7d3e671, 96'h0});
    chk("id_k2", seen[2], {32'h777fab08, 96'h0});

    golden = 1'b1;
    run_sched(rand128(), 3, -1, -1, 1'b0);
    run_sched(rand128(), -1, 6, -1, 1'b0);
    run_sched(rand128(), -1, -1, 7, 1'b0);
    run_sched(rand128(), -1, -1, -1, 1'b0);

    // Back-to-back: start held high, second key taken in the done cycle.
    k1 = rand128();
    k2 = rand128();
    run_sched(k1, -1, -1, -1, 1'b1);
    bus_if.key_in = k2;
    @(posedge clk); #1;
    chk("b2b_valid", 128'(bus_if.rk_valid), 128'(1));
    chk("b2b_index", 128'(bus_if.rk_index), 128'(0));
    chk("b2b_data", bus_if.rk_data, k2);
    bus_if.start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    repeat (3) run_sched(rand128(), -1, -1, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/anubis_key_sched_ctrl.md
Name: anubis_key_sched_ctrl

Overview:
Sequencer that drives Anubis 128-bit-key evolution (N=4, R=12) and emits the R+1 evolved key states K^0..K^R to the downstream round-key extraction stage over a valid/ready handshake. It generates the round index for the existing Round_Constants module, which it instantiates internally. It applies the round-constant XOR to the result of the external combinational key-evolution datapath (gamma/pi/theta): K^r = evo(K^(r-1)) xor c^r. It owns the only state register for the key schedule.

Parameters:
ROUNDS, 12, number of evolution rounds R; legal range 1..15, limited by the 4-bit index of Round_Constants.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
start  in  1  begin schedule; sampled only in IDLE
key_in  in  128  cipher key K^0; sampled in the cycle start is accepted
evo_state  out  128  current key state, fed to external evolution logic
evo_result  in  128  evolution function of evo_state (combinational, same cycle)
rk_valid  out  1  evolved key state available
rk_ready  in  1  downstream accepts rk_data
rk_data  out  128  evolved key state K^rk_index
rk_index  out  4  index r of rk_data, 0..ROUNDS
rk_last  out  1  high with rk_valid when rk_index==ROUNDS
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the final key is accepted

Behaviour:
- Reset values: state register=0, idx=0, FSM=IDLE; rk_valid=0, rk_last=0, busy=0, done=0, rk_data=0, rk_index=0. Reset has priority over all other inputs in any state, including mid-schedule. No partial output survives reset.
- Registers: key state KS[127:0], index idx[3:0], FSM {IDLE, EMIT, EVOLVE}, and done flop.
- Fixed assignments: evo_state=KS; rk_data=KS; rk_index=idx. Round_Constants round_counter input = idx+1, taken mod 16.
- IDLE: busy=0. If start=1, then KS<=key_in, idx<=0, and the FSM goes to EMIT. If start=0, hold.
- EMIT: rk_valid=1, and rk_last=(idx==ROUNDS). On rk_valid&&rk_ready:
  - if idx==ROUNDS, go to IDLE and set done<=1;
  - otherwise go to EVOLVE.
  - Without ready, KS, idx, rk_valid and rk_data hold stable for any number of cycles.
- EVOLVE: rk_valid=0. KS<=evo_result xor rc, where rc is the Round_Constants output for round idx+1. rc is nonzero only in bits [127:96]. Then idx<=idx+1 and the FSM goes to EMIT.
- done is high exactly one cycle: the first IDLE cycle after the final handshake. A start in that same cycle is accepted normally.
- start while busy=1 is ignored and has no effect on KS or idx.
- Latency: first rk_valid appears 1 cycle after start is accepted. Consecutive keys are at least 2 cycles apart (EMIT handshake, then EVOLVE). With rk_ready held at 1, a full schedule takes 2*ROUNDS+1 cycles from the start acceptance edge to the done pulse.
- The XOR is full 128-bit; bits [95:0] pass through evo_result unchanged.
- Exactly ROUNDS+1 handshakes occur per schedule. rk_index is strictly increasing, 0..ROUNDS.

Test Plan:
- Identity evolution (bench ties evo_result=evo_state), key_in=0, rk_ready=1, start pulse:
  - rk_index 0 → rk_data 0;
  - rk_index 1 → a7d3e671 followed by 96 zero bits;
  - rk_index 2 → 777fab08 followed by 96 zero bits;
  - 13 handshakes total, rk_last only on index 12, done pulses once at cycle 25 after start.
- Backpressure: hold rk_ready=0 for 5 cycles during index 3 → rk_valid stays 1 with rk_data/rk_index constant. Release → index 4 appears 2 cycles later with the correct value.
- Restart blocking: pulse start with a different key_in at index 6 → ignored; the schedule completes with the original key sequence.
- Reset mid-operation: assert rst at index 7 → next cycle rk_valid=0, busy=0, rk_index=0, done=0. A new start restarts at index 0 with the new key.
- Back-to-back schedules: start=1 held continuously → second schedule accepted in the done cycle; its rk_index 0 appears the following cycle.
- Reference model: evo_result driven by a golden gamma/pi/theta model, random keys → all 13 rk_data values match the Anubis spec key evolution.
